// File: rtl/controle_semaforo.sv
// Control FSM for the pedestrian-actuated crossing: sequences the 7 s / 5 s / 0.5 s
// timers through load/clear/fim, latches the pedestrian request and drives the lamps.
module controle_semaforo #(
    parameter int N_PISCA = 6,
    parameter int W_PISCA = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       botao,
    input  logic       fim_7s,
    input  logic       fim_5s,
    input  logic       fim_05s,
    output logic       load_Reg7s,
    output logic       clear_Reg7s,
    output logic       load_Reg5s,
    output logic       clear_Reg5s,
    output logic       load_Reg05s,
    output logic       clear_Reg05s,
    output logic       carro_verde,
    output logic       carro_amarelo,
    output logic       carro_vermelho,
    output logic       pedestre_verde,
    output logic       pedestre_vermelho,
    output logic       pedido,
    output logic [2:0] estado
);

    localparam logic [2:0] INICIO   = 3'd0;
    localparam logic [2:0] VERDE    = 3'd1;
    localparam logic [2:0] AMARELO  = 3'd2;
    localparam logic [2:0] VERMELHO = 3'd3;
    localparam logic [2:0] PISCA    = 3'd4;

    localparam logic [W_PISCA-1:0] ULTIMO = W_PISCA'(N_PISCA - 1);

    logic [2:0]         r_estado;
    logic [2:0]         w_prox;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_ant;
    logic               w_pulso;
    logic               r_pedido;
    logic [W_PISCA-1:0] r_cont;
    logic               r_fase;

    assign w_pulso = r_sync2 & ~r_sync_ant;

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIO:   w_prox = VERDE;
            VERDE:    if (fim_7s && r_pedido) w_prox = AMARELO;
            AMARELO:  if (fim_05s) w_prox = VERMELHO;
            VERMELHO: if (fim_5s) w_prox = PISCA;
            PISCA:    if (fim_05s && (r_cont == ULTIMO)) w_prox = VERDE;
            default:  w_prox = INICIO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado   <= INICIO;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_ant <= 1'b0;
            r_pedido   <= 1'b0;
            r_cont     <= '0;
            r_fase     <= 1'b1;
        end else begin
            r_estado   <= w_prox;
            r_sync1    <= botao;
            r_sync2    <= r_sync1;
            r_sync_ant <= r_sync2;
            case (r_estado)
                VERDE: begin
                    // Leaving green consumes the request; presses elsewhere never set it.
                    if (fim_7s && r_pedido) r_pedido <= 1'b0;
                    else if (w_pulso)       r_pedido <= 1'b1;
                end
                VERMELHO: begin
                    if (fim_5s) begin
                        r_cont <= '0;
                        r_fase <= 1'b1;
                    end
                end
                PISCA: begin
                    if (fim_05s) begin
                        r_fase <= ~r_fase;
                        if (r_cont == ULTIMO) r_cont <= '0;
                        else                  r_cont <= r_cont + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_Reg7s        = 1'b0;
        clear_Reg7s       = 1'b1;
        load_Reg5s        = 1'b0;
        clear_Reg5s       = 1'b1;
        load_Reg05s       = 1'b0;
        clear_Reg05s      = 1'b1;
        carro_verde       = 1'b0;
        carro_amarelo     = 1'b0;
        carro_vermelho    = 1'b1;
        pedestre_verde    = 1'b0;
        pedestre_vermelho = 1'b1;
        case (r_estado)
            VERDE: begin
                load_Reg7s     = 1'b1;
                clear_Reg7s    = 1'b0;
                carro_verde    = 1'b1;
                carro_vermelho = 1'b0;
            end
            AMARELO: begin
                load_Reg05s    = 1'b1;
                clear_Reg05s   = 1'b0;
                carro_amarelo  = 1'b1;
                carro_vermelho = 1'b0;
            end
            VERMELHO: begin
                load_Reg5s        = 1'b1;
                clear_Reg5s       = 1'b0;
                pedestre_verde    = 1'b1;
                pedestre_vermelho = 1'b0;
            end
            PISCA: begin
                // Restart the half-second timer on every pulse so each flash phase is full length.
                load_Reg05s       = 1'b1;
                clear_Reg05s      = fim_05s;
                pedestre_verde    = r_fase;
                pedestre_vermelho = 1'b0;
            end
            default: ;
        endcase
    end

    assign pedido = r_pedido;
    assign estado = r_estado;

endmodule

// File: tb/tb_controle_semaforo.sv
// Bench for controle_semaforo: directed phases plus random stimulus, checked
// against a phase/pulse-count reference model.
module tb_controle_semaforo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       botao = 1'b0;
    logic       fim_7s = 1'b0;
    logic       fim_5s = 1'b0;
    logic       fim_05s = 1'b0;
    logic       load_Reg7s, clear_Reg7s, load_Reg5s, clear_Reg5s, load_Reg05s, clear_Reg05s;
    logic       carro_verde, carro_amarelo, carro_vermelho, pedestre_verde, pedestre_vermelho;
    logic       pedido;
    logic [2:0] estado;

    int total = 0;
    int bad   = 0;

    // Reference model: crossing phase (0 start, 1 car green, 2 car yellow, 3 walk, 4 flashing),
    // count of half-second pulses seen while flashing, latched request, sampled button history.
    int   m_phase = 0;
    int   m_flash = 0;
    bit   m_ped   = 1'b0;
    bit [2:0] m_hist = '0;

    controle_semaforo #(.N_PISCA(6), .W_PISCA(3)) dut (
        .clk(clk), .rst(rst), .botao(botao),
        .fim_7s(fim_7s), .fim_5s(fim_5s), .fim_05s(fim_05s),
        .load_Reg7s(load_Reg7s), .clear_Reg7s(clear_Reg7s),
        .load_Reg5s(load_Reg5s), .clear_Reg5s(clear_Reg5s),
        .load_Reg05s(load_Reg05s), .clear_Reg05s(clear_Reg05s),
        .carro_verde(carro_verde), .carro_amarelo(carro_amarelo), .carro_vermelho(carro_vermelho),
        .pedestre_verde(pedestre_verde), .pedestre_vermelho(pedestre_vermelho),
        .pedido(pedido), .estado(estado)
    );

    always #20 clk = ~clk;

    function automatic logic [11:0] expected_outs();
        logic [11:0] e;
        // order: load7 clr7 load5 clr5 load05 clr05 cv ca cr pv pr pedido
        case (m_phase)
            1:       e = 12'b10_01_01_100_01_0;
            2:       e = 12'b01_01_10_010_01_0;
            3:       e = 12'b01_10_01_001_10_0;
            4:       e = {6'b01_01_1_0, 3'b001, 1'b0, 1'b0, 1'b0};
            default: e = 12'b01_01_01_001_01_0;
        endcase
        if (m_phase == 4) begin
            e[6] = fim_05s;
            e[2] = ((m_flash % 2) == 0);
        end
        e[0] = m_ped;
        return e;
    endfunction

    task automatic check();
        logic [11:0] got;
        logic [11:0] exp;
        logic        inv_ok;
        got = {load_Reg7s, clear_Reg7s, load_Reg5s, clear_Reg5s, load_Reg05s, clear_Reg05s,
               carro_verde, carro_amarelo, carro_vermelho, pedestre_verde, pedestre_vermelho, pedido};
        exp = expected_outs();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL outs t=%0t got=%b exp=%b", $time, got, exp);
        end
        total++;
        assert (estado === 3'(m_phase)) else begin
            bad++;
            $error("FAIL estado t=%0t got=%0d exp=%0d", $time, estado, m_phase);
        end
        inv_ok = ((32'(carro_verde) + 32'(carro_amarelo) + 32'(carro_vermelho)) <= 1) &&
                 !(carro_verde && pedestre_verde);
        total++;
        assert (inv_ok === 1'b1) else begin
            bad++;
            $error("FAIL invariant t=%0t got=%b exp=1", $time, inv_ok);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_flash = 0;
        m_ped   = 1'b0;
        m_hist  = '0;
    endtask

    task automatic model_edge();
        bit pulse;
        if (!rst) begin
            model_reset();
            return;
        end
        pulse  = m_hist[1] && !m_hist[2];
        m_hist = {m_hist[1:0], botao};
        case (m_phase)
            0: m_phase = 1;
            1: begin
                if (fim_7s && m_ped) begin
                    m_phase = 2;
                    m_ped   = 1'b0;
                end else if (pulse) begin
                    m_ped = 1'b1;
                end
            end
            2: if (fim_05s) m_phase = 3;
            3: if (fim_5s) begin
                m_phase = 4;
                m_flash = 0;
            end
            4: if (fim_05s) begin
                m_flash++;
                if (m_flash == 6) begin
                    m_phase = 1;
                    m_flash = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic cyc(input logic r, input logic b, input logic f7, input logic f5, input logic f05);
        @(negedge clk);
        rst = r; botao = b; fim_7s = f7; fim_5s = f5; fim_05s = f05;
        if (!r) model_reset();
        #1;
        check();
        model_edge();
    endtask

    task automatic reach_phase(input int ph, input int fl);
        int n;
        n = 0;
        while (!(m_phase == ph && m_flash == fl) && n < 400) begin
            cyc(1'b1, 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0));
            if (m_phase == 1 && !m_ped) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        total++;
        assert (n < 400) else begin
            bad++;
            $error("FAIL reach_phase got=%0d exp=%0d", m_phase, ph);
        end
    endtask

    initial begin
        // Reset held for three cycles, then release: one start cycle, then car green.
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Expired green timer without a request keeps green.
        repeat (20) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Yellow -> walk -> flashing with presses that must be ignored and random gaps.
        repeat ($urandom_range(1, 4)) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat ($urandom_range(1, 4)) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(1, 4)) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        repeat (6) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Random traffic: fim pulses and button toggles of varying density.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 9) < 3),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset mid-flash, away from any clock edge.
        reach_phase(4, 2);
        @(negedge clk);
        fim_05s = 1'b0;
        #7;
        rst = 1'b0;
        model_reset();
        #1;
        check();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #5;
        rst = 1'b1;
        #1;
        check();
        @(posedge clk);
        model_edge();
        #1;
        check();
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        reach_phase(4, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/controle_semaforo.md
Name: controle_semaforo

Overview:
Control FSM for the pedestrian-actuated crossing. It sequences the 7 s, 5 s and 0.5 s timer registers in the operational block through their load/clear/fim handshake, and latches the pedestrian button. It drives the car lights (green/yellow/red) and the pedestrian lights (green/red), with a flashing pedestrian-green phase before cars resume.

Parameters:
N_PISCA, 6, number of fim_05s pulses in the flashing phase (≥1, even); phase lasts N_PISCA × 0.5 s
W_PISCA, 3, width of the flash counter; must hold N_PISCA

Ports:
clk  in  1  system clock, 25 MHz
rst  in  1  asynchronous, active-low reset (0 = reset)
botao  in  1  raw pedestrian button, asynchronous to clk, active-high
fim_7s  in  1  7 s timer expired
fim_5s  in  1  5 s timer expired
fim_05s  in  1  0.5 s timer expired
load_Reg7s  out  1  enable 7 s count
clear_Reg7s  out  1  clear 7 s count
load_Reg5s  out  1  enable 5 s count
clear_Reg5s  out  1  clear 5 s count
load_Reg05s  out  1  enable 0.5 s count
clear_Reg05s  out  1  clear 0.5 s count
carro_verde  out  1  car green lamp
carro_amarelo  out  1  car yellow lamp
carro_vermelho  out  1  car red lamp
pedestre_verde  out  1  pedestrian green lamp
pedestre_vermelho  out  1  pedestrian red lamp
pedido  out  1  pedestrian request latched
estado  out  3  current state code, for debug

Behaviour:
- States and codes: INICIO=0, VERDE=1, AMARELO=2, VERMELHO=3, PISCA=4. Other codes fall back to INICIO on the next clk.
- Reset (rst=0, asynchronous):
  - state=INICIO, pedido=0, flash counter=0, fase=1, sync flops=0.
  - Outputs while in reset or INICIO: carro_vermelho=1, pedestre_vermelho=1, all other lamps 0; all clear_*=1; all load_*=0.
- Reset release mid-operation: the next posedge after rst returns to 1 starts from INICIO. Exactly one INICIO cycle, then VERDE.
- Button input:
  - Two-flop synchronizer, then rising-edge detect. One edge gives a one-cycle pulse.
  - pedido is set by the pulse only in state VERDE.
  - pedido is cleared on the transition VERDE→AMARELO. Presses in other states are ignored.
- Timer handshake (combinational from state, plus fim_05s in PISCA):
  - In a state, the timer that state owns has load=1 and clear=0. Every other timer has clear=1 and load=0. Each timer therefore starts from 0 on state entry.
  - Owners: VERDE→7s; AMARELO→05s; VERMELHO→5s; PISCA→05s.
  - In PISCA, clear_Reg05s = fim_05s, so the 0.5 s timer restarts every pulse.
- Transitions (registered, evaluated at posedge clk):
  - INICIO→VERDE unconditionally.
  - VERDE→AMARELO when fim_7s=1 and pedido=1. Green therefore lasts at least 7 s and holds indefinitely with no request.
  - A button edge in the same cycle fim_7s first rises: pedido sets next cycle and the transition follows one cycle later.
  - AMARELO→VERMELHO when fim_05s=1.
  - VERMELHO→PISCA when fim_5s=1. On entry: flash counter=0, fase=1.
  - PISCA: each cycle with fim_05s=1 increments the counter and toggles fase.
  - PISCA→VERDE when fim_05s=1 and counter==N_PISCA-1. The counter resets to 0.
- Lamps (Moore, from state, plus fase in PISCA):
  - VERDE: carro_verde, pedestre_vermelho.
  - AMARELO: carro_amarelo, pedestre_vermelho.
  - VERMELHO: carro_vermelho, pedestre_verde.
  - PISCA: carro_vermelho, pedestre_verde=fase, pedestre_vermelho=0.
- Invariant: at most one car lamp is high, and carro_verde is never high together with pedestre_verde.
- Simultaneous fim inputs: only the fim of the current state's owner is examined; the others are ignored.
- Latency: lamp and handshake outputs change in the cycle after the qualifying posedge (state register), except the PISCA clear_Reg05s, which follows fim_05s combinationally.

Test Plan:
1. rst=0 for 3 cycles, then release -> during reset and INICIO: carro_vermelho=pedestre_vermelho=1 and all clear_*=1. After one cycle: estado=1, load_Reg7s=1, clear_Reg5s=clear_Reg05s=1.
2. In VERDE, pulse fim_7s high for 20 cycles with botao=0 -> stays VERDE. Then press botao (held 5 cycles) -> pedido=1 after 3 cycles. With fim_7s=1: AMARELO on the next posedge and pedido=0.
3. Full cycle with timer stubs pulsing fim_* → AMARELO, then fim_05s → VERMELHO (pedestre_verde=1), then fim_5s → PISCA. Six fim_05s pulses -> pedestre_verde sequence 1,0,1,0,1,0, then estado=1.
4. In PISCA, assert fim_05s -> clear_Reg05s=1 in the same cycle, with load_Reg05s=1 throughout.
5. Press botao during AMARELO, VERMELHO and PISCA -> pedido stays 0. On the return to VERDE with fim_7s=1, the state stays VERDE.
6. Drive rst=0 asynchronously mid-PISCA (not on a clock edge) -> outputs go to reset values immediately and pedido=0. After release: INICIO→VERDE and the flash counter restarts at 0.
